// File: rtl/memory_pkg.sv
// Shared types and default sizes for the RAM request front-end.
// The controller has two states: IDLE serves requests, CLEAR sweeps zeros through the RAM.
package memory_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } mem_ctrl_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_RSP_DEPTH  = 4;

endpackage

// File: rtl/memory_rsp_fifo.sv
// In-order response FIFO: head is registered, a push becomes visible the cycle after it is written.
// No internal backpressure: the caller's credit scheme ensures it never overflows or underflows.
module memory_rsp_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             push_vld,
  input  logic [DATA_WIDTH-1:0]            push_dat,
  input  logic                             pop_rdy,
  output logic                             head_vld,
  output logic [DATA_WIDTH-1:0]            head_dat,
  output logic [$clog2(RSP_DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop_rdy)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push_vld, pop_rdy})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld) mem_q[wr_ptr_q] <= push_dat;
  end

  assign head_vld = (count_q != '0);
  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/memory_req_ctrl.sv
// Request front-end for a 1-cycle-latency single-port RAM; reads return >=2 cycles after accept.
// req_ready drops when queued plus in-flight reads reach RSP_DEPTH, or while clearing.
module memory_req_ctrl
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_input,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_output
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  mem_ctrl_state_t       state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  clear_done_q, clear_done_d;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]      credits;
  logic                  accept;
  logic                  pop;

  // Every read in flight owns a FIFO slot, so pushes can never find it full.
  assign credits   = fifo_count + CNT_W'(rd_pend_q);
  assign req_ready = reset_n && (state_q == IDLE) && !clear_start
                     && (credits < CNT_W'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    if (state_q == CLEAR) begin
      mem_address      = clr_cnt_q;
      mem_data_input   = '0;
      mem_write_enable = 1'b1;
    end else begin
      mem_address      = req_addr;
      mem_data_input   = req_wdata;
      mem_write_enable = accept && req_write;
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    clear_done_d = 1'b0;
    rd_pend_d    = accept && !req_write;
    if (state_q == IDLE) begin
      if (clear_start) state_d = CLEAR;
    end else begin
      clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
      if (clr_cnt_q == '1) begin
        state_d      = IDLE;
        clear_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      rd_pend_q    <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      rd_pend_q    <= rd_pend_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign clear_busy = (state_q == CLEAR);
  assign clear_done = clear_done_q;

  memory_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (rd_pend_q),
    .push_dat (mem_data_output),
    .pop_rdy  (pop),
    .head_vld (rsp_valid),
    .head_dat (rsp_rdata),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_memory_req_ctrl.sv
// Bench for memory_req_ctrl: a behavioural RAM plus a transaction-level reference model.
// Outputs are sampled on the falling edge, inputs change 1 time unit after the rising edge.
module tb_memory_req_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int WORDS = 1 << AW;

  logic          clk;
  logic          reset_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          clear_start, clear_busy, clear_done;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_input;
  logic          mem_write_enable;
  logic [DW-1:0] ram_dout;

  memory_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .clear_start      (clear_start),
    .clear_busy       (clear_busy),
    .clear_done       (clear_done),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_rdata        (rsp_rdata),
    .mem_address      (mem_address),
    .mem_data_input   (mem_data_input),
    .mem_write_enable (mem_write_enable),
    .mem_data_output  (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM with registered read data.
  logic [DW-1:0] ram [WORDS];
  always @(posedge clk) begin
    if (mem_write_enable) ram[mem_address] <= mem_data_input;
    else                  ram_dout <= ram[mem_address];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word contents, reads not yet consumed (with accept cycle), clear progress.
  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } ent_t;
  ent_t          q[$];
  logic [DW-1:0] mm [WORDS];
  int            cyc = 0;
  int            clear_left = 0;
  int            clear_idx = 0;
  logic          done_flag = 1'b0;

  initial begin : compare
    logic idle, e_ready, e_valid, e_we;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_mem_we", mem_write_enable, 0);
        q.delete();
        clear_left = 0;
        done_flag  = 1'b0;
      end else begin
        idle    = (clear_left == 0);
        e_ready = idle && !clear_start && (q.size() < DEPTH);
        e_valid = (q.size() > 0) && (cyc - q[0].t >= 2);
        e_we    = idle ? (req_valid && e_ready && req_write) : 1'b1;
        chk("req_ready", req_ready, e_ready);
        chk("rsp_valid", rsp_valid, e_valid);
        chk("clear_busy", clear_busy, !idle);
        chk("clear_done", clear_done, done_flag);
        chk("mem_we", mem_write_enable, e_we);
        if (e_valid) chk("rsp_rdata", rsp_rdata, q[0].d);
        if (idle) chk("mem_address", mem_address, req_addr);
        else      chk("clear_address", mem_address, clear_idx);
        if (e_we) chk("mem_data_input", mem_data_input, idle ? req_wdata : 8'h00);

        done_flag = 1'b0;
        if (e_valid && rsp_ready) void'(q.pop_front());
        if (idle) begin
          if (req_valid && e_ready) begin
            if (req_write) mm[req_addr] = req_wdata;
            else           q.push_back('{mm[req_addr], cyc});
          end
          if (clear_start) begin
            clear_left = WORDS;
            clear_idx  = 0;
          end
        end else begin
          mm[clear_idx] = '0;
          clear_idx++;
          clear_left--;
          if (clear_left == 0) done_flag = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready;
      step();
    end
    req_valid = 1'b0;
    if (!ok) chk("req_accept_timeout", ok, 1);
  endtask

  initial begin : driver
    int n, nz, busy, done, acc;
    logic accepted;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; clear_start = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    step(); step();
    reset_n = 1'b1;

    for (int i = 0; i < WORDS; i++) do_req(1'b1, AW'(i), 8'(8'h30 + i));

    // Back-to-back reads of 0..7.
    n = 0;
    for (int i = 0; i < 12; i++) begin
      req_valid = (i < 8); req_write = 1'b0; req_addr = AW'(i);
      @(negedge clk);
      if (i < 8) chk("b2b_req_ready", req_ready, 1);
      if (rsp_valid) begin
        chk("b2b_rdata", rsp_rdata, 8'h30 + n);
        n++;
      end
      step();
    end
    req_valid = 1'b0;
    chk("b2b_rsp_count", n, 8);

    // Backpressure: only DEPTH reads may be outstanding.
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(8 + acc);
      @(negedge clk);
      if (req_ready) acc++;
      step();
    end
    @(negedge clk);
    chk("bp_ready_low", req_ready, 0);
    chk("bp_accepted", acc, 4);
    step();
    req_valid = 1'b0; rsp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        chk("bp_rdata", rsp_rdata, 8'h38 + n);
        n++;
      end
      step();
    end
    chk("bp_rsp_count", n, 4);

    // Write then read the same word on the next cycle.
    do_req(1'b1, 4'hA, 8'hA5);
    do_req(1'b0, 4'hA, 8'h00);
    @(negedge clk);
    chk("wr_rd_early_valid", rsp_valid, 0);
    step();
    @(negedge clk);
    chk("wr_rd_valid", rsp_valid, 1);
    chk("wr_rd_data", rsp_rdata, 8'hA5);
    step();
    @(negedge clk);
    chk("wr_rd_single_rsp", rsp_valid, 0);
    step();

    // Clear colliding with a read request; second clear_start mid-clear.
    clear_start = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 4'h3;
    @(negedge clk);
    chk("collide_ready", req_ready, 0);
    step();
    clear_start = 1'b0;
    busy = 0; done = 0; accepted = 1'b0;
    for (int i = 0; i < 30; i++) begin
      clear_start = (i == 3);
      if (accepted) req_valid = 1'b0;
      @(negedge clk);
      if (clear_busy) busy++;
      if (clear_done) begin
        done++;
        chk("ready_at_done", req_ready, 1);
      end
      if (req_valid && req_ready) accepted = 1'b1;
      step();
    end
    clear_start = 1'b0; req_valid = 1'b0;
    chk("clear_busy_cycles", busy, WORDS);
    chk("clear_done_pulses", done, 1);
    chk("collide_accepted_later", accepted, 1);

    n = 0; nz = 0;
    for (int i = 0; i < 22; i++) begin
      req_valid = (i < WORDS); req_write = 1'b0; req_addr = AW'(i);
      @(negedge clk);
      if (rsp_valid) begin
        n++;
        if (rsp_rdata != 8'h00) nz++;
      end
      step();
    end
    req_valid = 1'b0;
    chk("post_clear_rsp_count", n, WORDS);
    chk("post_clear_nonzero", nz, 0);

    // Reset in the middle of a clear with two responses queued.
    for (int i = 0; i < WORDS; i++) do_req(1'b1, AW'(i), 8'hFF);
    rsp_ready = 1'b0;
    do_req(1'b0, 4'h1, 8'h00);
    do_req(1'b0, 4'h2, 8'h00);
    step(); step(); step();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_clear_busy", clear_busy, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_mem_we", mem_write_enable, 0);
    step(); step();
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    n = 0; done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) n++;
      if (clear_done) done++;
      step();
    end
    chk("post_reset_stale_rsp", n, 0);
    chk("post_reset_no_done", done, 0);

    // Randomised traffic checked by the model.
    for (int i = 0; i < 1500; i++) begin
      req_valid   = ($urandom_range(0, 3) != 0);
      req_write   = $urandom_range(0, 1) == 1;
      req_addr    = AW'($urandom_range(0, WORDS - 1));
      req_wdata   = DW'($urandom);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      clear_start = ($urandom_range(0, 199) == 0);
      step();
    end
    req_valid = 1'b0; clear_start = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 40; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
